// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder for add/or/sll/andi/bne/sh/lh.
// Symbolic requests come in over a valid/ready handshake. Each legal request
// leaves as a 32-bit word tagged with a sequential instruction-memory address.
// Build option INSTR_ENC_SKID_EN: when defined, output staging is a 2-entry
// skid buffer with a registered in_ready. When undefined, staging is a single
// output register and in_ready is a combinational pass-through.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_ANDI = 3'd3;
    localparam logic [2:0] OP_BNE  = 3'd4;
    localparam logic [2:0] OP_SH   = 3'd5;
    localparam logic [2:0] OP_LH   = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    logic [31:0]       w_enc;
    logic              w_legal;
    logic              w_in_xfer;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] r_pc;
    logic              r_err;
    logic [15:0]       r_word_count;

    // Combinational encoding of the request currently presented on in_*.
    always_comb begin
        w_enc = '0;
        case (in_op)
            OP_ADD:  w_enc = {7'b0, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            OP_OR:   w_enc = {7'b0, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
            OP_SLL:  w_enc = {7'b0, in_rs2, in_rs1, 3'b001, in_rd, 7'b0110011};
            OP_ANDI: w_enc = {in_imm[11:0], in_rs1, 3'b111, in_rd, 7'b0010011};
            OP_BNE:  w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            OP_SH:   w_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b001, in_imm[4:0], 7'b0100011};
            OP_LH:   w_enc = {in_imm[11:0], in_rs1, 3'b001, in_rd, 7'b0000011};
            default: w_enc = '0;
        endcase
    end

    // Illegal ops and odd branch offsets are consumed but never staged.
    assign w_legal   = (in_op != OP_ILL) && !((in_op == OP_BNE) && in_imm[0]);
    assign w_in_xfer = in_valid && in_ready;
    assign w_push    = w_in_xfer && w_legal;
    assign w_pop     = out_valid && out_ready;

    // Address counter advances only for words that will actually be emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= L_BASE;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(4);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_in_xfer && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    // Count of output-side transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_count <= '0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign err        = r_err;
    assign word_count = r_word_count;

`ifdef INSTR_ENC_SKID_EN
    // Entry 0 is the head and drives the outputs; entry 1 only fills when the
    // head is blocked. in_ready is registered from the next occupancy so it
    // never depends combinationally on out_ready.
    logic [1:0]        r_count;
    logic [1:0]        w_count_nxt;
    logic              r_in_ready;
    logic [31:0]       r_instr0;
    logic [31:0]       r_instr1;
    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;

    // Next occupancy of the skid buffer.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Occupancy, registered ready, and FIFO data movement.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_instr0   <= '0;
            r_addr0    <= L_BASE;
            r_instr1   <= '0;
            r_addr1    <= L_BASE;
        end else begin
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_instr0 <= r_instr1;
                    r_addr0  <= r_addr1;
                    if (w_push) begin
                        r_instr1 <= w_enc;
                        r_addr1  <= r_pc;
                    end
                end else if (w_push) begin
                    r_instr0 <= w_enc;
                    r_addr0  <= r_pc;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_instr0 <= w_enc;
                    r_addr0  <= r_pc;
                end else begin
                    r_instr1 <= w_enc;
                    r_addr1  <= r_pc;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_instr = r_instr0;
    assign out_addr  = r_addr0;
`else
    // Single output register; a new word may replace the old one in the same
    // cycle the consumer takes it.
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;

    // Output register load on accept, clear when drained with nothing behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= L_BASE;
        end else if (w_push) begin
            r_valid <= 1'b1;
            r_instr <= w_enc;
            r_addr  <= r_pc;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_addr  = r_addr;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; expectations follow the build option
// INSTR_ENC_SKID_EN where buffer depth matters.
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0100;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_ANDI = 3'd3;
    localparam logic [2:0] OP_BNE  = 3'd4;
    localparam logic [2:0] OP_SH   = 3'd5;
    localparam logic [2:0] OP_LH   = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

`ifdef INSTR_ENC_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;
    int idx_in;
    int idx_out;
    logic [31:0] exp_word;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .word_count(word_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm);
        int cnt = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        @(negedge clk);
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("send_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_word_count", {16'b0, word_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        next_cycle();

        // add x3, x1, x2
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_instr", out_instr, 32'h002081B3);
        chk("add_addr", out_addr, BASE);
        next_cycle();
        @(negedge clk);
        chk("add_word_count", {16'b0, word_count}, 32'd1);
        chk("add_drained", {31'b0, out_valid}, 32'd0);
        next_cycle();

        // andi then bne with negative offset, fresh address space
        do_reset();
        send(OP_ANDI, 5'd5, 5'd6, 5'd0, 13'h00FF);
        @(negedge clk);
        chk("andi_instr", out_instr, 32'h0FF37293);
        chk("andi_addr", out_addr, BASE);
        next_cycle();
        send(OP_BNE, 5'd0, 5'd1, 5'd2, 13'h1FFC);
        @(negedge clk);
        chk("bne_instr", out_instr, 32'hFE209EE3);
        chk("bne_addr", out_addr, BASE + 32'd4);
        next_cycle();
        @(negedge clk);
        chk("bne_word_count", {16'b0, word_count}, 32'd2);
        next_cycle();
        send(OP_OR, 5'd4, 5'd5, 5'd6, 13'd0);
        @(negedge clk);
        chk("or_instr", out_instr, 32'h0062E233);
        chk("or_addr", out_addr, BASE + 32'd8);
        next_cycle();
        send(OP_SLL, 5'd7, 5'd8, 5'd9, 13'd0);
        @(negedge clk);
        chk("sll_instr", out_instr, 32'h009413B3);
        chk("sll_addr", out_addr, BASE + 32'd12);
        next_cycle();

        // Back-to-back lh at full throughput
        in_valid = 1'b1; in_op = OP_LH; in_rs1 = 5'd2; in_rs2 = 5'd0; in_imm = 13'd0;
        in_rd = 5'd10;
        @(negedge clk);
        chk("tp0_in_ready", {31'b0, in_ready}, 32'd1);
        next_cycle();
        in_rd = 5'd11;
        @(negedge clk);
        chk("tp1_in_ready", {31'b0, in_ready}, 32'd1);
        chk("tp1_instr", out_instr, 32'h00011503);
        chk("tp1_addr", out_addr, BASE + 32'd16);
        next_cycle();
        in_rd = 5'd12;
        @(negedge clk);
        chk("tp2_in_ready", {31'b0, in_ready}, 32'd1);
        chk("tp2_instr", out_instr, 32'h00011583);
        chk("tp2_addr", out_addr, BASE + 32'd20);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("tp3_instr", out_instr, 32'h00011603);
        chk("tp3_addr", out_addr, BASE + 32'd24);
        next_cycle();
        send(OP_LH, 5'd1, 5'd2, 5'd0, 13'h1FFE);
        @(negedge clk);
        chk("lh_neg_instr", out_instr, 32'hFFE11083);
        chk("lh_neg_addr", out_addr, BASE + 32'd28);
        next_cycle();

        // Backpressure: sh held stable while out_ready is low
        do_reset();
        out_ready = 1'b0;
        send(OP_SH, 5'd0, 5'd1, 5'd2, 13'd6);
        @(negedge clk);
        chk("sh_instr", out_instr, 32'h00209323);
        chk("sh_addr", out_addr, BASE);
        chk("sh_in_ready_after1", {31'b0, in_ready}, {31'b0, SKID});
        next_cycle();
        if (SKID) begin
            send(OP_LH, 5'd1, 5'd2, 5'd0, 13'd0);
            @(negedge clk);
            chk("skid_in_ready_after2", {31'b0, in_ready}, 32'd0);
            next_cycle();
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_instr", out_instr, 32'h00209323);
            chk("hold_addr", out_addr, BASE);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_sh", out_instr, 32'h00209323);
        next_cycle();
        if (SKID) begin
            @(negedge clk);
            chk("drain_lh_instr", out_instr, 32'h00011083);
            chk("drain_lh_addr", out_addr, BASE + 32'd4);
            next_cycle();
        end
        @(negedge clk);
        chk("drain_empty", {31'b0, out_valid}, 32'd0);
        next_cycle();

        // Rejected requests
        do_reset();
        send(OP_ILL, 5'd1, 5'd1, 5'd1, 13'd0);
        @(negedge clk);
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_no_out", {31'b0, out_valid}, 32'd0);
        next_cycle();
        send(OP_BNE, 5'd0, 5'd1, 5'd2, 13'd3);
        @(negedge clk);
        chk("misalign_no_out", {31'b0, out_valid}, 32'd0);
        next_cycle();
        send(OP_LH, 5'd1, 5'd2, 5'd0, 13'd0);
        @(negedge clk);
        chk("rej_lh_instr", out_instr, 32'h00011083);
        chk("rej_lh_addr", out_addr, BASE);
        chk("rej_err_sticky", {31'b0, err}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("rej_word_count", {16'b0, word_count}, 32'd1);
        next_cycle();

        // Stream of 10 adds under random backpressure
        do_reset();
        idx_in  = 0;
        idx_out = 0;
        for (int cyc = 0; cyc < 400 && idx_out < 10; cyc++) begin
            if (idx_in < 10) begin
                in_valid = 1'b1;
                in_op    = OP_ADD;
                in_rd    = 5'(idx_in + 1);
                in_rs1   = 5'(idx_in + 2);
                in_rs2   = 5'(idx_in + 3);
                in_imm   = 13'd0;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid && out_ready) begin
                exp_word = {7'b0, 5'(idx_out + 3), 5'(idx_out + 2), 3'b000,
                            5'(idx_out + 1), 7'b0110011};
                chk("stream_instr", out_instr, exp_word);
                chk("stream_addr", out_addr, BASE + 32'(4 * idx_out));
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_complete", 32'(idx_out), 32'd10);
        @(negedge clk);
        chk("stream_word_count", {16'b0, word_count}, 32'd10);
        chk("stream_empty", {31'b0, out_valid}, 32'd0);
        next_cycle();

        // Reset mid-stream with buffered word and pending handshakes
        out_ready = 1'b0;
        send(OP_ILL, 5'd0, 5'd0, 5'd0, 13'd0);
        send(OP_ADD, 5'd9, 5'd9, 5'd9, 13'd0);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_err", {31'b0, err}, 32'd1);
        next_cycle();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_word_count", {16'b0, word_count}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        next_cycle();
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        chk("post_rst_addr", out_addr, BASE);
        chk("post_rst_instr", out_instr, 32'h002081B3);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the datapath's instruction decoder. It accepts symbolic operations (op select, register indices, immediate) over a valid/ready handshake and emits 32-bit instruction words. Each word carries a sequential instruction-memory address. Test harnesses and the boot loader use it to fill instruction memory with the supported subset: add, or, sll, andi, bne, sh, lh.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address assigned to the first emitted word.
- `ADDR_W`, default 32: width of `out_addr` and the address counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request valid.
- `in_ready` output 1: encoder can accept this cycle.
- `in_op` input 3: 0 add, 1 or, 2 sll, 3 andi, 4 bne, 5 sh, 6 lh, 7 illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices; fields the op does not use are ignored.
- `in_imm` input 13: signed immediate; I/S types use [11:0]; bne uses [12:1] as the byte offset.
- `out_valid` output 1: encoded word available.
- `out_ready` input 1: consumer accepts the word.
- `out_instr` output 32: encoded instruction.
- `out_addr` output ADDR_W: address of `out_instr`.
- `err` output 1: sticky error flag.
- `word_count` output 16: number of words transferred on the output side; wraps.

## Operation
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- Encodings, as {fields}, opcode last:
  - add/or/sll: {7'b0, rs2, rs1, f3, rd, 7'b0110011}, with f3 = 000 / 110 / 001.
  - andi: {imm[11:0], rs1, 3'b111, rd, 7'b0010011}.
  - lh: {imm[11:0], rs1, 3'b001, rd, 7'b0000011}.
  - sh: {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0100011}.
  - bne: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
- Rejected requests:
  - `in_op`=7, or bne with `in_imm[0]`=1 (misaligned branch).
  - The request is consumed (handshake completes normally) but produces no output word.
  - `err` sets to 1. The address counter does not advance.
- Address counter:
  - Reset value: BASE_ADDR.
  - Each accepted, legal request is tagged with the current counter value, and the counter then increments by 4. Wraps modulo 2^ADDR_W.
- `word_count` increments on each output transfer. Wraps 16'hFFFF -> 0.
- Output ordering is strictly FIFO; no word is dropped or duplicated under backpressure.
- Reset values:
  - `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `err`=0, `word_count`=0.
  - `in_ready`=1 in the cycle after reset deasserts.
- Reset asserted mid-stream discards all buffered words, regardless of handshake state in that cycle.
- `err` clears only on reset.

## Timing
- Latency is 1 cycle: a word accepted at edge N is presented with `out_valid`=1 from edge N onward, i.e. usable in cycle N+1.
- `out_instr`/`out_addr` come directly from registers, with no combinational path from the `in_*` fields.
- `out_instr`/`out_addr` must hold stable while `out_valid && !out_ready`.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Simultaneous input and output transfer on a full buffer is allowed in the pass-through case (see Configuration). The occupancy is unchanged.

## Configuration
- `INSTR_ENC_SKID_EN` defined:
  - 2-entry skid buffer.
  - `in_ready` = buffer not full, registered, with no combinational dependence on `out_ready`.
- `INSTR_ENC_SKID_EN` undefined:
  - Single output register.
  - `in_ready` = !`out_valid` || `out_ready` (combinational pass-through).
- Encoding, error and counter behaviour are identical in both builds.

## Test plan
- add rd=3, rs1=1, rs2=2, `out_ready`=1 -> next cycle `out_instr`=0x002081B3, `out_addr`=BASE_ADDR, `word_count`=1.
- andi rd=5, rs1=6, imm=0x0FF, then bne rs1=1, rs2=2, imm=-4 -> 0x0FF37293 at BASE_ADDR, then 0xFE209EE3 at BASE_ADDR+4.
- sh rs1=1, rs2=2, imm=6, with `out_ready` held 0 for 5 cycles -> 0x00209323 held stable throughout.
  - With skid: `in_ready` drops after 2 accepted words.
  - Without skid: `in_ready` drops after 1 accepted word.
- `in_op`=7, then bne with imm=3, then lh rd=1, rs1=2, imm=0 -> `err`=1, no output for the first two requests, lh word 0x00011083 at BASE_ADDR.
- Stream of 10 words with random `out_ready`, then reset mid-stream -> all 10 in order with consecutive addresses; after reset `out_valid`=0, `err`=0, `word_count`=0, and the next word goes to BASE_ADDR.
